// File: rtl/mitll_pulse_splitter_pkg.sv
// Shared constants and types for the RSFQ splitter model.
// Delay-line depth, separation-counter sizing and parameter defaults.
package mitll_splitter_pkg;

    localparam int DELAY_MAX = 64;

    localparam int SEP_W = 8;
    typedef logic [SEP_W-1:0] sep_cnt_t;
    localparam sep_cnt_t SEP_SAT = '1;

    localparam int DEFAULT_DELAY1  = 5;
    localparam int DEFAULT_DELAY2  = 5;
    localparam int DEFAULT_MIN_SEP = 3;

    function automatic sep_cnt_t sep_inc(input sep_cnt_t cnt);
        return (cnt == SEP_SAT) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/mitll_pulse_splitter_if.sv
// Pulse bus of the splitter: one transition-encoded input, two copies out,
// plus the separation-violation flag.
interface mitll_pulse_splitter_if;

    logic in;
    logic out1;
    logic out2;
    logic viol;

    modport master (output in, input out1, input out2, input viol);
    modport slave  (input in, output out1, output out2, output viol);

endinterface

// File: rtl/mitll_pulse_delay.sv
// Single-bit event delay line; the output register toggles once for every
// event that reaches the end of the line, DELAY cycles after it entered.
module mitll_pulse_delay
    import mitll_splitter_pkg::*;
#(
    parameter int DELAY = DEFAULT_DELAY1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ev,
    output logic pulse
);

    logic [DELAY-1:0] line;

    if (DELAY == 1) begin : g_line_one
        always_ff @(posedge clk) begin
            if (!rst_n) line <= '0;
            else        line <= ev;
        end
    end else begin : g_line_shift
        always_ff @(posedge clk) begin
            if (!rst_n) line <= '0;
            else        line <= {line[DELAY-2:0], ev};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pulse <= 1'b0;
        else        pulse <= pulse ^ line[DELAY-1];
    end

endmodule

// File: rtl/mitll_pulse_splitter.sv
// RSFQ splitter model: duplicates each input transition onto out1/out2 with
// independent fixed delays. MITLL_SPLITTER_TIMING_CHECK_EN enables viol.
module mitll_pulse_splitter
    import mitll_splitter_pkg::*;
#(
    parameter int DELAY1  = DEFAULT_DELAY1,
    parameter int DELAY2  = DEFAULT_DELAY2,
    parameter int MIN_SEP = DEFAULT_MIN_SEP
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mitll_pulse_splitter_if.slave  bus
);

    if (DELAY1 < 1 || DELAY1 > DELAY_MAX) begin : g_bad_delay1
        $error("DELAY1 out of range 1..%0d", DELAY_MAX);
    end
    if (DELAY2 < 1 || DELAY2 > DELAY_MAX) begin : g_bad_delay2
        $error("DELAY2 out of range 1..%0d", DELAY_MAX);
    end
    if (MIN_SEP < 1 || MIN_SEP > 255) begin : g_bad_min_sep
        $error("MIN_SEP out of range 1..255");
    end

    logic in_q;
    logic ev;

    // Loading in_q during reset too means a level held across release is not an event.
    always_ff @(posedge clk) begin
        in_q <= bus.in;
    end

    assign ev = (bus.in ^ in_q) & rst_n;

    mitll_pulse_delay #(.DELAY(DELAY1)) u_delay1 (
        .clk   (clk),
        .rst_n (rst_n),
        .ev    (ev),
        .pulse (bus.out1)
    );

    mitll_pulse_delay #(.DELAY(DELAY2)) u_delay2 (
        .clk   (clk),
        .rst_n (rst_n),
        .ev    (ev),
        .pulse (bus.out2)
    );

`ifdef MITLL_SPLITTER_TIMING_CHECK_EN
    localparam sep_cnt_t MIN_SEP_C = sep_cnt_t'(MIN_SEP);

    sep_cnt_t sep_cnt;
    logic     viol_q;

    // sep_cnt holds the distance back to the previous event as seen at this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sep_cnt <= SEP_SAT;
            viol_q  <= 1'b0;
        end else if (ev) begin
            sep_cnt <= sep_cnt_t'(1);
            viol_q  <= (sep_cnt < MIN_SEP_C);
        end else begin
            sep_cnt <= sep_inc(sep_cnt);
            viol_q  <= 1'b0;
        end
    end

    assign bus.viol = viol_q;
`else
    assign bus.viol = 1'b0;
`endif

endmodule

// File: tb/tb_mitll_pulse_splitter.sv
// Directed bench for mitll_pulse_splitter: a per-cycle vector table for two
// delay configurations plus hand sequences for reset and delay extremes.
module tb_mitll_pulse_splitter;

    logic clk;
    logic rst_n;

    mitll_pulse_splitter_if if_a ();
    mitll_pulse_splitter_if if_b ();
    mitll_pulse_splitter_if if_c ();

    mitll_pulse_splitter u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    mitll_pulse_splitter #(.DELAY1(2), .DELAY2(7), .MIN_SEP(3)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    mitll_pulse_splitter #(.DELAY1(1), .DELAY2(64), .MIN_SEP(1)) u_dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst_n;
        logic in;
        logic o1a;
        logic o2a;
        logic o1b;
        logic o2b;
        logic v;
    } vec_t;

    localparam int N_VEC = 51;
    vec_t vec [N_VEC];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic rng(input int k, input int lo, input int hi);
        return (k >= lo) && (k <= hi);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int at, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %b want %b", nm, at, act, exp);
        end
    endtask

    function automatic logic exp_viol(input logic v);
`ifdef MITLL_SPLITTER_TIMING_CHECK_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    initial begin
        rst_n     = 1'b0;
        if_a.in   = 1'b0;
        if_b.in   = 1'b0;
        if_c.in   = 1'b0;

        // Events at edges 10,14,20,21,30,33,40,42; viol at 21 (sep 1) and 42 (sep 2), not 33 (sep 3).
        for (int k = 0; k < N_VEC; k++) begin
            vec[k].rst_n = (k >= 4);
            vec[k].in    = rng(k,10,13) | rng(k,20,20) | rng(k,30,32) | rng(k,40,41);
            vec[k].o1a   = rng(k,15,18) | rng(k,25,25) | rng(k,35,37) | rng(k,45,46);
            vec[k].o2a   = vec[k].o1a;
            vec[k].o1b   = rng(k,12,15) | rng(k,22,22) | rng(k,32,34) | rng(k,42,43);
            vec[k].o2b   = rng(k,17,20) | rng(k,27,27) | rng(k,37,39) | rng(k,47,48);
            vec[k].v     = (k == 21) || (k == 42);
        end

        for (int k = 0; k < N_VEC; k++) begin
            rst_n   = vec[k].rst_n;
            if_a.in = vec[k].in;
            if_b.in = vec[k].in;
            cyc();
            chk("out1_a", k, if_a.out1, vec[k].o1a);
            chk("out2_a", k, if_a.out2, vec[k].o2a);
            chk("viol_a", k, if_a.viol, exp_viol(vec[k].v));
            chk("out1_b", k, if_b.out1, vec[k].o1b);
            chk("out2_b", k, if_b.out2, vec[k].o2b);
            chk("viol_b", k, if_b.viol, exp_viol(vec[k].v));
            chk("out1_c_idle", k, if_c.out1, 1'b0);
        end

        // Reset released with in held high, including a toggle coincident with reset.
        rst_n   = 1'b0;
        if_a.in = 1'b1;
        if_b.in = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("rst_in1_out1_a", i, if_a.out1, 1'b0);
            chk("rst_in1_out2_a", i, if_a.out2, 1'b0);
            chk("rst_in1_out1_b", i, if_b.out1, 1'b0);
            chk("rst_in1_out2_b", i, if_b.out2, 1'b0);
            chk("rst_in1_viol_a", i, if_a.viol, 1'b0);
        end

        // Reset two cycles after a toggle drops the in-flight pulse.
        if_a.in = 1'b0;
        if_b.in = 1'b0;
        cyc();
        chk("flight_out1_b_t0", 0, if_b.out1, 1'b0);
        cyc();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("flight_out1_a", i, if_a.out1, 1'b0);
            chk("flight_out2_a", i, if_a.out2, 1'b0);
            chk("flight_out1_b", i, if_b.out1, 1'b0);
            chk("flight_out2_b", i, if_b.out2, 1'b0);
        end

        // Delay extremes: DELAY1=1, DELAY2=64, back-to-back events, MIN_SEP=1.
        if_c.in = 1'b1;
        cyc();
        chk("c_out1_x0", 0, if_c.out1, 1'b0);
        chk("c_viol_x0", 0, if_c.viol, 1'b0);
        if_c.in = 1'b0;
        cyc();
        chk("c_out1_x1", 1, if_c.out1, 1'b1);
        chk("c_viol_x1", 1, if_c.viol, 1'b0);
        cyc();
        chk("c_out1_x2", 2, if_c.out1, 1'b0);
        chk("c_out2_x2", 2, if_c.out2, 1'b0);
        for (int i = 0; i < 61; i++) cyc();
        chk("c_out2_x63", 63, if_c.out2, 1'b0);
        cyc();
        chk("c_out2_x64", 64, if_c.out2, 1'b1);
        cyc();
        chk("c_out2_x65", 65, if_c.out2, 1'b0);
        chk("c_out1_x65", 65, if_c.out1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
